// File: rtl/rob_if.sv
// Bundle of allocation, writeback, operand-read and commit signals between the
// out-of-order core stages and the reorder buffer.
interface rob_if #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 2,
  parameter int WBP   = 4,
  parameter int RP    = 4,
  parameter int DW    = 32
);
  localparam int TW = $clog2(DEPTH);

  logic [WIDTH-1:0]    alloc_valid;
  logic [WIDTH-1:0]    alloc_rden;
  logic [5*WIDTH-1:0]  alloc_rdl;
  logic [32*WIDTH-1:0] alloc_pc;
  logic [WIDTH-1:0]    alloc_store;
  logic                alloc_ready;
  logic [TW*WIDTH-1:0] alloc_tag;

  logic [WBP-1:0]      wb_valid;
  logic [TW*WBP-1:0]   wb_tag;
  logic [DW*WBP-1:0]   wb_data;
  logic [WBP-1:0]      wb_mispred;
  logic [32*WBP-1:0]   wb_target;

  logic [TW*RP-1:0]    rp_tag;
  logic [RP-1:0]       rp_valid;
  logic [DW*RP-1:0]    rp_data;

  logic [WIDTH-1:0]    commit_valid;
  logic [WIDTH-1:0]    commit_rden;
  logic [5*WIDTH-1:0]  commit_rdl;
  logic [TW*WIDTH-1:0] commit_tag;
  logic [DW*WIDTH-1:0] commit_data;
  logic [WIDTH-1:0]    commit_store;
  logic                flush;
  logic [31:0]         flush_pc;
  logic [TW:0]         count;

  modport master (
    output alloc_valid, alloc_rden, alloc_rdl, alloc_pc, alloc_store,
    output wb_valid, wb_tag, wb_data, wb_mispred, wb_target, rp_tag,
    input  alloc_ready, alloc_tag, rp_valid, rp_data,
    input  commit_valid, commit_rden, commit_rdl, commit_tag, commit_data,
    input  commit_store, flush, flush_pc, count
  );

  modport slave (
    input  alloc_valid, alloc_rden, alloc_rdl, alloc_pc, alloc_store,
    input  wb_valid, wb_tag, wb_data, wb_mispred, wb_target, rp_tag,
    output alloc_ready, alloc_tag, rp_valid, rp_data,
    output commit_valid, commit_rden, commit_rdl, commit_tag, commit_data,
    output commit_store, flush, flush_pc, count
  );
endinterface

// File: rtl/rob_multiport.sv
// N-wide reorder buffer: in-order allocate/retire, multi-port writeback,
// operand forwarding to register read, and flush on a retired mispredict.
module rob_multiport #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 2,
  parameter int WBP   = 4,
  parameter int RP    = 4,
  parameter int DW    = 32
) (
  input logic   clk1,
  input logic   reset,
  rob_if.slave  rob
);
  localparam int TW = $clog2(DEPTH);
  localparam logic [TW:0] CNT_MAX = (TW+1)'(DEPTH - WIDTH);

  logic [DEPTH-1:0] valid, done, rden, store, mispred;
  logic [4:0]       rdl    [DEPTH];
  logic [DW-1:0]    data   [DEPTH];
  logic [31:0]      target [DEPTH];

  logic [TW-1:0]       head, tail, sel_idx, rp_t;
  logic [TW:0]         count, nalloc, ncommit;
  logic                ready, stop, flush_sel;
  logic [31:0]         flush_sel_pc;
  logic [TW*WIDTH-1:0] tag_c;
  logic [RP-1:0]       rpv_c;
  logic [DW*RP-1:0]    rpd_c;

  assign ready           = (count <= CNT_MAX);
  assign rob.alloc_ready = ready;
  assign rob.alloc_tag   = tag_c;
  assign rob.count       = count;
  assign rob.rp_valid    = rpv_c;
  assign rob.rp_data     = rpd_c;

  always_comb begin
    tag_c  = '0;
    nalloc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      tag_c[i*TW +: TW] = tail + TW'(i);
      if (rob.alloc_valid[i]) nalloc = nalloc + (TW+1)'(1);
    end
    if (!ready) nalloc = '0;
  end

  // Retire group: leading done entries, closed by (and including) a mispredict.
  always_comb begin
    ncommit      = '0;
    flush_sel    = 1'b0;
    flush_sel_pc = '0;
    stop         = 1'b0;
    sel_idx      = head;
    for (int i = 0; i < WIDTH; i++) begin
      sel_idx = head + TW'(i);
      if (!stop) begin
        if (valid[sel_idx] && done[sel_idx]) begin
          ncommit = ncommit + (TW+1)'(1);
          if (mispred[sel_idx]) begin
            flush_sel    = 1'b1;
            flush_sel_pc = target[sel_idx];
            stop         = 1'b1;
          end
        end else begin
          stop = 1'b1;
        end
      end
    end
  end

  // Same-cycle writeback bypass; later ports override earlier ones.
  always_comb begin
    rpv_c = '0;
    rpd_c = '0;
    rp_t  = '0;
    for (int r = 0; r < RP; r++) begin
      rp_t = rob.rp_tag[r*TW +: TW];
      rpv_c[r] = valid[rp_t] & done[rp_t];
      rpd_c[r*DW +: DW] = data[rp_t];
      for (int p = 0; p < WBP; p++) begin
        if (rob.wb_valid[p] && rob.wb_tag[p*TW +: TW] == rp_t && valid[rp_t]) begin
          rpv_c[r] = 1'b1;
          rpd_c[r*DW +: DW] = rob.wb_data[p*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      valid             <= '0;
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      rob.commit_valid  <= '0;
      rob.commit_rden   <= '0;
      rob.commit_rdl    <= '0;
      rob.commit_tag    <= '0;
      rob.commit_data   <= '0;
      rob.commit_store  <= '0;
      rob.flush         <= 1'b0;
      rob.flush_pc      <= '0;
    end else begin
      for (int p = 0; p < WBP; p++) begin
        if (rob.wb_valid[p] && valid[rob.wb_tag[p*TW +: TW]]) begin
          done[rob.wb_tag[p*TW +: TW]]    <= 1'b1;
          data[rob.wb_tag[p*TW +: TW]]    <= rob.wb_data[p*DW +: DW];
          mispred[rob.wb_tag[p*TW +: TW]] <= rob.wb_mispred[p];
          target[rob.wb_tag[p*TW +: TW]]  <= rob.wb_target[p*32 +: 32];
        end
      end
      for (int i = 0; i < WIDTH; i++) begin
        if ((TW+1)'(i) < ncommit) begin
          rob.commit_valid[i]         <= 1'b1;
          rob.commit_rden[i]          <= rden[head + TW'(i)];
          rob.commit_rdl[i*5 +: 5]    <= rdl[head + TW'(i)];
          rob.commit_tag[i*TW +: TW]  <= head + TW'(i);
          rob.commit_data[i*DW +: DW] <= data[head + TW'(i)];
          rob.commit_store[i]         <= store[head + TW'(i)];
          valid[head + TW'(i)]        <= 1'b0;
        end else begin
          rob.commit_valid[i]         <= 1'b0;
          rob.commit_rden[i]          <= 1'b0;
          rob.commit_rdl[i*5 +: 5]    <= '0;
          rob.commit_tag[i*TW +: TW]  <= '0;
          rob.commit_data[i*DW +: DW] <= '0;
          rob.commit_store[i]         <= 1'b0;
        end
      end
      rob.flush    <= flush_sel;
      rob.flush_pc <= flush_sel_pc;
      if (flush_sel) begin
        valid <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          if (ready && rob.alloc_valid[i]) begin
            valid[tail + TW'(i)]   <= 1'b1;
            done[tail + TW'(i)]    <= 1'b0;
            mispred[tail + TW'(i)] <= 1'b0;
            rden[tail + TW'(i)]    <= rob.alloc_rden[i];
            rdl[tail + TW'(i)]     <= rob.alloc_rdl[i*5 +: 5];
            store[tail + TW'(i)]   <= rob.alloc_store[i];
          end
        end
        head  <= head + ncommit[TW-1:0];
        tail  <= tail + nalloc[TW-1:0];
        count <= count + nalloc - ncommit;
      end
    end
  end
endmodule

// File: tb/tb_rob_multiport.sv
// Randomised scoreboard bench for rob_multiport: a program-order queue model
// predicts each retire group, flush, occupancy, tags and operand reads.
module tb_rob_multiport;
  localparam int DEPTH = 32;
  localparam int WIDTH = 2;
  localparam int WBP   = 4;
  localparam int RP    = 4;
  localparam int DW    = 32;
  localparam int TW    = $clog2(DEPTH);

  logic clk1;
  logic reset;

  rob_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .WBP(WBP), .RP(RP), .DW(DW)) u_if ();

  rob_multiport #(.DEPTH(DEPTH), .WIDTH(WIDTH), .WBP(WBP), .RP(RP), .DW(DW)) u_dut (
    .clk1  (clk1),
    .reset (reset),
    .rob   (u_if)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  int checks   = 0;
  int failures = 0;

  // Reference model: tags of live entries in program order plus per-tag info.
  int          q[$];
  int          m_tail;
  bit          m_done  [DEPTH];
  bit          m_mp    [DEPTH];
  bit          m_rden  [DEPTH];
  bit          m_store [DEPTH];
  logic [4:0]  m_rdl   [DEPTH];
  logic [DW-1:0] m_data[DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  logic [31:0] m_pc    [DEPTH];

  // Predicted retire group for the next edge.
  int          pk;
  bit          pflush;
  logic [31:0] ppc;
  int          ptag  [WIDTH];
  logic [DW-1:0] pdata[WIDTH];
  logic [4:0]  prdl  [WIDTH];
  bit          prden [WIDTH];
  bit          pstore[WIDTH];
  logic [31:0] ppcs  [WIDTH];

  typedef struct { int idx; bit v; logic [DW-1:0] d; } rpe_t;
  rpe_t rpq[$];

  bit run;

  logic [WBP-1:0]    s_wv, s_wm;
  logic [TW*WBP-1:0] s_wt;
  logic [DW*WBP-1:0] s_wd;
  logic [32*WBP-1:0] s_wg;
  logic [TW*RP-1:0]  s_rt;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic bit in_q(input int t);
    foreach (q[i]) if (q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic predict();
    int t;
    pk = 0; pflush = 1'b0; ppc = '0;
    for (int i = 0; i < WIDTH && i < q.size(); i++) begin
      t = q[i];
      if (!m_done[t]) break;
      ptag[pk] = t; pdata[pk] = m_data[t]; prdl[pk] = m_rdl[t];
      prden[pk] = m_rden[t]; pstore[pk] = m_store[t]; ppcs[pk] = m_pc[t];
      pk++;
      if (m_mp[t]) begin
        pflush = 1'b1;
        ppc = m_tgt[t];
        break;
      end
    end
  endtask

  task automatic mon();
    for (int i = 0; i < WIDTH; i++) begin
      chk($sformatf("commit_valid[%0d]", i), 64'(u_if.commit_valid[i]), 64'(i < pk));
      if (i < pk) begin
        chk($sformatf("commit_tag[%0d]", i), 64'(u_if.commit_tag[i*TW +: TW]), 64'(ptag[i]));
        chk($sformatf("commit_rdl[%0d] pc=%0h", i, ppcs[i]), 64'(u_if.commit_rdl[i*5 +: 5]), 64'(prdl[i]));
        chk($sformatf("commit_rden[%0d]", i), 64'(u_if.commit_rden[i]), 64'(prden[i]));
        chk($sformatf("commit_store[%0d]", i), 64'(u_if.commit_store[i]), 64'(pstore[i]));
        chk($sformatf("commit_data[%0d]", i), 64'(u_if.commit_data[i*DW +: DW]), 64'(pdata[i]));
      end
    end
    chk("flush", 64'(u_if.flush), 64'(pflush));
    if (pflush) chk("flush_pc", 64'(u_if.flush_pc), 64'(ppc));
    for (int i = 0; i < pk; i++) void'(q.pop_front());
    if (pflush) begin
      q.delete();
      m_tail = 0;
    end
    chk("count", 64'(u_if.count), 64'(q.size()));
    chk("alloc_ready", 64'(u_if.alloc_ready), 64'((DEPTH - q.size()) >= WIDTH));
    for (int i = 0; i < WIDTH; i++)
      chk($sformatf("alloc_tag[%0d]", i), 64'(u_if.alloc_tag[i*TW +: TW]), 64'((m_tail + i) % DEPTH));
    predict();
  endtask

  always @(negedge clk1) if (run) mon();

  always @(negedge clk1) begin
    rpe_t e;
    #3;
    while (rpq.size() > 0) begin
      e = rpq.pop_front();
      chk($sformatf("rp_valid[%0d]", e.idx), 64'(u_if.rp_valid[e.idx]), 64'(e.v));
      if (e.v) chk($sformatf("rp_data[%0d]", e.idx), 64'(u_if.rp_data[e.idx*DW +: DW]), 64'(e.d));
    end
  end

  task automatic step(input int nal, input logic [WBP-1:0] wv, input logic [TW*WBP-1:0] wt,
                      input logic [DW*WBP-1:0] wd, input logic [WBP-1:0] wm,
                      input logic [32*WBP-1:0] wg, input logic [TW*RP-1:0] rt);
    bit ar;
    int t;
    rpe_t e;
    logic [WIDTH-1:0] av;
    ar = (DEPTH - q.size()) >= WIDTH;
    for (int r = 0; r < RP; r++) begin
      t = int'(rt[r*TW +: TW]);
      e.idx = r; e.v = in_q(t) && m_done[t]; e.d = m_data[t];
      for (int p = 0; p < WBP; p++)
        if (wv[p] && int'(wt[p*TW +: TW]) == t && in_q(t)) begin
          e.v = 1'b1; e.d = wd[p*DW +: DW];
        end
      rpq.push_back(e);
    end
    for (int p = 0; p < WBP; p++) begin
      t = int'(wt[p*TW +: TW]);
      if (wv[p] && in_q(t)) begin
        m_done[t] = 1'b1; m_data[t] = wd[p*DW +: DW];
        m_mp[t] = wm[p]; m_tgt[t] = wg[p*32 +: 32];
      end
    end
    u_if.wb_valid = wv; u_if.wb_tag = wt; u_if.wb_data = wd;
    u_if.wb_mispred = wm; u_if.wb_target = wg; u_if.rp_tag = rt;
    av = '0;
    for (int i = 0; i < nal; i++) av[i] = 1'b1;
    u_if.alloc_valid = av;
    u_if.alloc_rden  = WIDTH'($urandom);
    u_if.alloc_store = WIDTH'($urandom);
    for (int i = 0; i < WIDTH; i++) begin
      u_if.alloc_rdl[i*5 +: 5] = 5'($urandom);
      u_if.alloc_pc[i*32 +: 32] = $urandom;
    end
    if (ar) begin
      for (int i = 0; i < nal; i++) begin
        t = (m_tail + i) % DEPTH;
        m_done[t] = 1'b0; m_mp[t] = 1'b0;
        m_rden[t] = u_if.alloc_rden[i]; m_store[t] = u_if.alloc_store[i];
        m_rdl[t] = u_if.alloc_rdl[i*5 +: 5]; m_pc[t] = u_if.alloc_pc[i*32 +: 32];
        q.push_back(t);
      end
      m_tail = (m_tail + nal) % DEPTH;
    end
  endtask

  task automatic tick();
    @(negedge clk1);
    #1;
  endtask

  task automatic clr();
    s_wv = '0; s_wm = '0; s_wt = '0; s_wd = '0; s_wg = '0; s_rt = '0;
  endtask

  task automatic wb_set(input int p, input int t, input logic [DW-1:0] d, input bit m,
                        input logic [31:0] g);
    s_wv[p] = 1'b1; s_wt[p*TW +: TW] = TW'(t); s_wd[p*DW +: DW] = d;
    s_wm[p] = m; s_wg[p*32 +: 32] = g;
  endtask

  task automatic dstep(input int nal);
    tick();
    step(nal, s_wv, s_wt, s_wd, s_wm, s_wg, s_rt);
    clr();
  endtask

  task automatic rand_step(input int nal_max, input int wb_pct, input bit mp_en);
    int undone[$];
    int t;
    logic [WBP-1:0]    wv, wm;
    logic [TW*WBP-1:0] wt;
    logic [DW*WBP-1:0] wd;
    logic [32*WBP-1:0] wg;
    logic [TW*RP-1:0]  rt;
    foreach (q[i]) if (!m_done[q[i]]) undone.push_back(q[i]);
    wv = '0; wm = '0; wt = '0; wd = '0; wg = '0; rt = '0;
    for (int p = 0; p < WBP; p++) begin
      if (int'($urandom_range(99)) < wb_pct) begin
        if (undone.size() > 0 && $urandom_range(3) != 0)
          t = undone[$urandom_range(undone.size() - 1)];
        else
          t = int'($urandom_range(DEPTH - 1));
        if (!(in_q(t) && m_done[t])) begin
          wv[p] = 1'b1;
          wt[p*TW +: TW] = TW'(t);
          wd[p*DW +: DW] = $urandom;
          wm[p] = mp_en && ($urandom_range(47) == 0);
          wg[p*32 +: 32] = $urandom;
        end
      end
    end
    for (int r = 0; r < RP; r++) begin
      case ($urandom_range(3))
        0: rt[r*TW +: TW] = wt[$urandom_range(WBP - 1)*TW +: TW];
        1, 2: rt[r*TW +: TW] = (q.size() > 0) ? TW'(q[$urandom_range(q.size() - 1)]) : TW'($urandom);
        default: rt[r*TW +: TW] = TW'($urandom);
      endcase
    end
    step(int'($urandom_range(nal_max)), wv, wt, wd, wm, wg, rt);
  endtask

  task automatic zero_inputs();
    u_if.alloc_valid = '0; u_if.alloc_rden = '0; u_if.alloc_rdl = '0;
    u_if.alloc_pc = '0; u_if.alloc_store = '0;
    u_if.wb_valid = '0; u_if.wb_tag = '0; u_if.wb_data = '0;
    u_if.wb_mispred = '0; u_if.wb_target = '0; u_if.rp_tag = '0;
  endtask

  task automatic model_reset();
    q.delete(); m_tail = 0; pk = 0; pflush = 1'b0; ppc = '0;
  endtask

  task automatic reset_checks();
    chk("rst_count", 64'(u_if.count), 64'(0));
    chk("rst_alloc_ready", 64'(u_if.alloc_ready), 64'(1));
    chk("rst_commit_valid", 64'(u_if.commit_valid), 64'(0));
    chk("rst_flush", 64'(u_if.flush), 64'(0));
    chk("rst_flush_pc", 64'(u_if.flush_pc), 64'(0));
  endtask

  initial begin
    int budget;
    run = 1'b0;
    reset = 1'b1;
    zero_inputs();
    clr();
    model_reset();
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    reset_checks();
    #1 reset = 1'b0;
    run = 1'b1;

    // Two allocs, out-of-order writeback, joint retire.
    dstep(2);
    wb_set(0, 1, 32'h0000_0011, 1'b0, '0); dstep(0);
    wb_set(1, 0, 32'h0000_0022, 1'b0, '0); dstep(0);
    dstep(0); dstep(0);
    // In-order hold: younger entry waits for its own writeback.
    dstep(2);
    wb_set(0, 2, 32'h0000_0033, 1'b0, '0); dstep(0);
    dstep(0); dstep(0);
    wb_set(3, 3, 32'h0000_0044, 1'b0, '0); dstep(0);
    dstep(0); dstep(0);
    // Mispredict at the oldest entry; allocation on the flush edge is dropped.
    dstep(2);
    wb_set(0, 4, 32'h0000_0055, 1'b1, 32'h0040_0100);
    wb_set(1, 5, 32'h0000_0066, 1'b0, '0); dstep(0);
    dstep(2);
    dstep(0);
    // Same-cycle writeback bypass with port priority, plus an invalid tag.
    dstep(2); dstep(2); dstep(2);
    wb_set(0, 5, 32'h1111_1111, 1'b0, '0);
    wb_set(2, 5, 32'hDEAD_BEEF, 1'b0, '0);
    s_rt = {TW'(0), TW'(5), TW'(31), TW'(5)};
    dstep(0);
    s_rt = {TW'(0), TW'(5), TW'(31), TW'(5)};
    dstep(0);

    // Fill to full, then retire one and two entries at the head.
    repeat (20) dstep(WIDTH);
    wb_set(0, q[0], 32'h0000_0077, 1'b0, '0); dstep(WIDTH);
    dstep(WIDTH); dstep(WIDTH);
    wb_set(0, q[0], 32'h0000_0088, 1'b0, '0);
    wb_set(1, q[1], 32'h0000_0099, 1'b0, '0); dstep(WIDTH);
    dstep(0); dstep(0);

    repeat (250) begin tick(); rand_step(WIDTH, 50, 1'b0); end
    repeat (200) begin tick(); rand_step(WIDTH, 60, 1'b1); end

    // Mid-operation reset with live inputs that must be ignored.
    tick();
    run = 1'b0;
    reset = 1'b1;
    u_if.alloc_valid = '1;
    u_if.wb_valid = '1;
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    reset_checks();
    #1 reset = 1'b0;
    zero_inputs();
    model_reset();
    run = 1'b1;

    repeat (100) begin tick(); rand_step(WIDTH, 50, 1'b1); end

    budget = 0;
    while ((q.size() > 0 || pk > 0) && budget < 300) begin
      tick();
      rand_step(0, 100, 1'b0);
      budget++;
    end
    if (q.size() > 0 || pk > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got=%0d exp=0", q.size());
    end
    tick(); clr(); step(0, s_wv, s_wt, s_wd, s_wm, s_wg, s_rt);
    tick(); step(0, s_wv, s_wt, s_wd, s_wm, s_wg, s_rt);
    @(negedge clk1);
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
